// File: rtl/window_address_sequencer.sv
// Self-sequencing sliding-window address generator: walks every output position and channel,
// emitting KxK NHWC input addresses per window over a valid/ready handshake.
// Optional zero-padding support is enabled by defining ADDR_SEQ_PAD_EN.
module window_address_sequencer #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MAX_KERNEL = 3
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_rst,
  input  logic                                                 i_start,
  input  logic                                                 i_reg_clear,
  input  logic [ADDR_WIDTH-1:0]                                i_i_size,
  input  logic [ADDR_WIDTH-1:0]                                i_i_c_size,
  input  logic [ADDR_WIDTH-1:0]                                i_k_size,
  input  logic [ADDR_WIDTH-1:0]                                i_stride,
  input  logic [ADDR_WIDTH-1:0]                                i_pad,
  input  logic [ADDR_WIDTH-1:0]                                i_start_addr,
  input  logic                                                 i_ready,
  output logic                                                 o_valid,
  output logic [0:MAX_KERNEL*MAX_KERNEL-1][ADDR_WIDTH-1:0]     o_addr,
  output logic [0:MAX_KERNEL*MAX_KERNEL-1]                     o_mask,
  output logic [ADDR_WIDTH-1:0]                                o_o_x,
  output logic [ADDR_WIDTH-1:0]                                o_o_y,
  output logic [ADDR_WIDTH-1:0]                                o_i_c,
  output logic [ROWS-1:0]                                      o_row_id,
  output logic                                                 o_busy,
  output logic                                                 o_done
);

  localparam int unsigned LANES = MAX_KERNEL * MAX_KERNEL;
  localparam int unsigned WW    = 2 * ADDR_WIDTH;
  localparam int unsigned SW    = 2 * ADDR_WIDTH + 2;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cfg_i_q, cfg_c_q, cfg_k_q, cfg_s_q, cfg_base_q;
  logic [ADDR_WIDTH-1:0] pad_v;
  logic [WW-1:0]         num_q;
  logic                  cfg_load_c;

  logic                                     valid_d, busy_d, done_d;
  logic [0:LANES-1][ADDR_WIDTH-1:0]         addr_d, win_addr_c;
  logic [0:LANES-1]                         mask_d, win_mask_c;
  logic [ADDR_WIDTH-1:0]                    x_d, y_d, c_d, nx, ny, nc;
  logic [ROWS-1:0]                          row_d;

  logic [WW-1:0]   span_c, num_c;
  logic            empty_c, last_c, xfer_c;
  logic [SW-1:0]   ix, iy;
  int unsigned     lane_i;
  logic            in_c;

  assign cfg_load_c = (state_q == S_IDLE) && i_start;
  assign xfer_c     = o_valid && i_ready;

  // Configuration is captured only when a sweep is started.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) begin
      cfg_i_q    <= '0;
      cfg_c_q    <= '0;
      cfg_k_q    <= '0;
      cfg_s_q    <= '0;
      cfg_base_q <= '0;
      num_q      <= '0;
    end else begin
      if (cfg_load_c) begin
        cfg_i_q    <= i_i_size;
        cfg_c_q    <= i_i_c_size;
        cfg_k_q    <= i_k_size;
        cfg_s_q    <= i_stride;
        cfg_base_q <= i_start_addr;
      end
      if (state_q == S_SETUP) num_q <= num_c;
    end
  end

`ifdef ADDR_SEQ_PAD_EN
  logic [ADDR_WIDTH-1:0] cfg_p_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) cfg_p_q <= '0;
    else if (cfg_load_c)      cfg_p_q <= i_pad;
  end

  assign pad_v = cfg_p_q;
`else
  logic unused_pad;

  assign unused_pad = ^i_pad;
  assign pad_v      = '0;
`endif

  // Output extent and the degenerate kernel-larger-than-input case.
  assign span_c  = WW'(cfg_i_q) + (WW'(pad_v) << 1);
  assign empty_c = WW'(cfg_k_q) > span_c;
  assign num_c   = (span_c - WW'(cfg_k_q)) / WW'(cfg_s_q) + WW'(1);
  assign last_c  = (WW'(o_i_c) + WW'(1) >= WW'(cfg_c_q)) &&
                   (WW'(o_o_y) + WW'(1) >= num_q) &&
                   (WW'(o_o_x) + WW'(1) >= num_q);

  // Next window position: channel innermost, then o_y, then o_x.
  always_comb begin
    nx = o_o_x;
    ny = o_o_y;
    nc = o_i_c;
    if (state_q == S_SETUP) begin
      nx = '0;
      ny = '0;
      nc = '0;
    end else if (WW'(o_i_c) + WW'(1) < WW'(cfg_c_q)) begin
      nc = o_i_c + ADDR_WIDTH'(1);
    end else begin
      nc = '0;
      if (WW'(o_o_y) + WW'(1) < num_q) begin
        ny = o_o_y + ADDR_WIDTH'(1);
      end else begin
        ny = '0;
        nx = o_o_x + ADDR_WIDTH'(1);
      end
    end
  end

  // Lane addresses for the next window; negative coordinates wrap high and fail the bound test.
  always_comb begin
    win_addr_c = '0;
    win_mask_c = '0;
    ix         = '0;
    iy         = '0;
    lane_i     = 0;
    in_c       = 1'b0;
    for (int unsigned kx = 0; kx < MAX_KERNEL; kx++) begin
      for (int unsigned ky = 0; ky < MAX_KERNEL; ky++) begin
        ix     = SW'(nx) * SW'(cfg_s_q) + SW'(kx) - SW'(pad_v);
        iy     = SW'(ny) * SW'(cfg_s_q) + SW'(ky) - SW'(pad_v);
        lane_i = ky + kx * 32'(cfg_k_q);
`ifdef ADDR_SEQ_PAD_EN
        in_c   = (ix < SW'(cfg_i_q)) && (iy < SW'(cfg_i_q));
`else
        in_c   = 1'b1;
`endif
        if ((ADDR_WIDTH'(kx) < cfg_k_q) && (ADDR_WIDTH'(ky) < cfg_k_q) &&
            (lane_i < LANES) && in_c) begin
          win_mask_c[LW'(lane_i)] = 1'b1;
          win_addr_c[LW'(lane_i)] = ADDR_WIDTH'(WW'(cfg_base_q) +
              (WW'(ix) * WW'(cfg_i_q) + WW'(iy)) * WW'(cfg_c_q) + WW'(nc));
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) state_q <= S_IDLE;
    else                      state_q <= state_d;
  end

  // Next state and next registered outputs.
  always_comb begin
    logic load_win;
    state_d  = state_q;
    valid_d  = o_valid;
    addr_d   = o_addr;
    mask_d   = o_mask;
    x_d      = o_o_x;
    y_d      = o_o_y;
    c_d      = o_i_c;
    row_d    = o_row_id;
    load_win = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SETUP;
          row_d   = ROWS'(1);
        end
      end
      S_SETUP: begin
        if (empty_c) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_RUN;
          load_win = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer_c) begin
          row_d = {o_row_id[ROWS-2:0], o_row_id[ROWS-1]};
          if (last_c) state_d = S_DONE;
          else        load_win = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load_win) begin
      valid_d = 1'b1;
      addr_d  = win_addr_c;
      mask_d  = win_mask_c;
      x_d     = nx;
      y_d     = ny;
      c_d     = nc;
    end else if (state_d != S_RUN) begin
      valid_d = 1'b0;
      addr_d  = '0;
      mask_d  = '0;
      x_d     = '0;
      y_d     = '0;
      c_d     = '0;
    end
    if (state_d == S_IDLE && !(state_q == S_IDLE && i_start)) row_d = '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) begin
      o_valid  <= 1'b0;
      o_addr   <= '0;
      o_mask   <= '0;
      o_o_x    <= '0;
      o_o_y    <= '0;
      o_i_c    <= '0;
      o_row_id <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_valid  <= valid_d;
      o_addr   <= addr_d;
      o_mask   <= mask_d;
      o_o_x    <= x_d;
      o_o_y    <= y_d;
      o_i_c    <= c_d;
      o_row_id <= row_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
    end
  end

endmodule
